// File: rtl/id_regfile_pkg.sv
// id_regfile_pkg: shared constants and helpers for the ThinPad decode register file.
// Decode and write-back import this so both sides agree on special indices.
package id_regfile_pkg;

  // Default geometry of the register file
  localparam int DATA_W_DEF   = 16;
  localparam int ADDR_W_DEF   = 4;
  localparam int NUM_RD_DEF   = 2;
  localparam int NULL_REG_DEF = (1 << ADDR_W_DEF) - 1;

  // Special register indices shared by decode and write-back
  localparam int REG_SP = 8;
  localparam int REG_T  = 9;
  localparam int REG_IH = 10;

  // Per-entry scoreboard action for one clock edge
  typedef enum logic [1:0] {
    SB_HOLD  = 2'd0,
    SB_SET   = 2'd1,
    SB_CLEAR = 2'd2,
    SB_FLUSH = 2'd3
  } sb_op_e;

  // Resolves competing scoreboard events on one entry.
  // A flush drops everything, including a same-cycle issue; a new load
  // beats a same-cycle write-back because the load now owns the register.
  function automatic sb_op_e sb_entry_op(input logic flush_hit,
                                         input logic set_hit,
                                         input logic clr_hit);
    sb_op_e op;
    if (flush_hit) begin
      op = SB_FLUSH;
    end else if (set_hit) begin
      op = SB_SET;
    end else if (clr_hit) begin
      op = SB_CLEAR;
    end else begin
      op = SB_HOLD;
    end
    return op;
  endfunction

endpackage

// File: rtl/id_regfile_scoreboard.sv
// id_scoreboard: tracks registers waiting on an in-flight load and raises
// the decode stall when a read port depends on one of them.
module id_scoreboard
  import id_regfile_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int NULL_REG = (1 << ADDR_W) - 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  input  logic                     i_wb_en,
  input  logic [ADDR_W-1:0]        i_wb_addr,
  input  logic                     i_iss_en,
  input  logic                     i_iss_load,
  input  logic [ADDR_W-1:0]        i_iss_addr,
  input  logic                     i_flush,
  output logic                     o_stall,
  output logic [(1<<ADDR_W)-1:0]   o_busy
);

  localparam int              NUM_REGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] L_NULL = ADDR_W'(NULL_REG);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_next;
  logic [NUM_RD-1:0]   w_port_stall;
  logic                w_issue_load;

  assign w_issue_load = i_iss_en & i_iss_load & (i_iss_addr != L_NULL);

  // Next busy vector: each entry independently resolves flush/set/clear
  always_comb begin
    w_busy_next = r_busy;
    for (int i = 0; i < NUM_REGS; i++) begin
      case (sb_entry_op(i_flush,
                        w_issue_load && (i_iss_addr == ADDR_W'(i)),
                        i_wb_en && (i_wb_addr == ADDR_W'(i))))
        SB_FLUSH: w_busy_next[i] = 1'b0;
        SB_SET:   w_busy_next[i] = 1'b1;
        SB_CLEAR: w_busy_next[i] = 1'b0;
        default:  w_busy_next[i] = r_busy[i];
      endcase
    end
  end

  // Busy vector register; reset leaves no load pending
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  // A port stalls on a pending load unless the load result is arriving now
  for (genvar k = 0; k < NUM_RD; k++) begin : g_port
    logic [ADDR_W-1:0] w_addr;
    assign w_addr          = i_rd_addr[k*ADDR_W +: ADDR_W];
    assign w_port_stall[k] = (w_addr != L_NULL) & r_busy[w_addr]
                             & ~(i_wb_en & (i_wb_addr == w_addr));
  end

  assign o_stall = i_rst_n & (|w_port_stall);
  assign o_busy  = r_busy;

endmodule

// File: rtl/id_regfile.sv
// id_regfile: ThinPad decode-stage register file with write-back bypass
// and a load-use scoreboard that stalls decode on pending loads.
module id_regfile
  import id_regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int NULL_REG = (1 << ADDR_W) - 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0] o_rd_data,
  input  logic                     i_wb_en,
  input  logic [ADDR_W-1:0]        i_wb_addr,
  input  logic [DATA_W-1:0]        i_wb_data,
  input  logic                     i_iss_en,
  input  logic                     i_iss_load,
  input  logic [ADDR_W-1:0]        i_iss_addr,
  input  logic                     i_flush,
  output logic                     o_stall,
  output logic [(1<<ADDR_W)-1:0]   o_busy
);

  localparam int              NUM_REGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] L_NULL = ADDR_W'(NULL_REG);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              w_wr_en;

  // The null index is never written, so its storage entry stays constant zero
  assign w_wr_en = i_wb_en & (i_wb_addr != L_NULL);

  // Register storage: write-back port, cleared by reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[i_wb_addr] <= i_wb_data;
    end
  end

  // Read ports: null reads zero, a same-cycle write-back is bypassed
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    assign w_addr = i_rd_addr[k*ADDR_W +: ADDR_W];

    // Read mux for one port; outputs forced to zero while in reset
    always_comb begin
      w_data = '0;
      if (!i_rst_n) begin
        w_data = '0;
      end else if (w_addr == L_NULL) begin
        w_data = '0;
      end else if (i_wb_en && (i_wb_addr == w_addr)) begin
        w_data = i_wb_data;
      end else begin
        w_data = r_regs[w_addr];
      end
    end

    assign o_rd_data[k*DATA_W +: DATA_W] = w_data;
  end

  id_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .NULL_REG (NULL_REG)
  ) u_scoreboard (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_rd_addr  (i_rd_addr),
    .i_wb_en    (i_wb_en),
    .i_wb_addr  (i_wb_addr),
    .i_iss_en   (i_iss_en),
    .i_iss_load (i_iss_load),
    .i_iss_addr (i_iss_addr),
    .i_flush    (i_flush),
    .o_stall    (o_stall),
    .o_busy     (o_busy)
  );

endmodule

// File: doc/id_regfile.md
# id_regfile

Parametrised register file and load-use scoreboard for the decode stage of the 16-bit ThinPad CPU. It holds general and special registers (SP, T, IH), serves the decode read ports with same-cycle write-back bypass, and raises a stall when a source register still awaits an in-flight load. It sits between instruction decode (read addresses, issue info) and the write-back stage (write port).

## Interface
Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 4, register index width; 2**ADDR_W entries
- NUM_RD, 2, number of read ports
- NULL_REG, 2**ADDR_W-1, "no register" index: reads as 0, never written, never busy

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- rd_addr  in  NUM_RD*ADDR_W  read indices, port k at [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
- wb_en  in  1  write-back strobe
- wb_addr  in  ADDR_W  write-back index
- wb_data  in  DATA_W  write-back value
- iss_en  in  1  instruction leaves decode this cycle
- iss_load  in  1  issuing instruction is a load (LW, LW_SP)
- iss_addr  in  ADDR_W  destination of issuing instruction
- flush  in  1  pipeline flush (branch/jump taken)
- stall  out  1  decode must hold
- busy  out  2**ADDR_W  scoreboard vector, bit i = load pending on reg i

## Operation
- Storage: 2**ADDR_W x DATA_W registers; entry NULL_REG is not implemented and reads 0.
- Write: at posedge, if wb_en and wb_addr != NULL_REG, reg[wb_addr] <= wb_data.
- Read, per port k, priority: rd_addr == NULL_REG -> 0; wb_en and wb_addr == rd_addr -> wb_data (bypass); else reg[rd_addr].
- Scoreboard set: at posedge, iss_en & iss_load & iss_addr != NULL_REG sets busy[iss_addr].
- Scoreboard clear: at posedge, wb_en clears busy[wb_addr].
- Set and clear of the same index in one cycle: set wins (new load owns the register).
- flush: at posedge clears every busy bit; an issue in the same cycle is dropped (flush wins).
- stall = OR over ports k of (rd_addr_k != NULL_REG & busy[rd_addr_k] & !(wb_en & wb_addr == rd_addr_k)).
- iss_en while stall is high is a decode bug; the block still applies the set rule.

## Timing
- rd_data and stall: combinational from rd_addr, wb_*, busy, state; zero latency.
- Write visible via bypass in the write cycle, from storage the next cycle onward.
- busy updates one cycle after the issuing/write-back edge.
- Load-use: load issued at edge N -> dependent read stalls from cycle N+1 until the cycle wb_en with matching wb_addr is presented (stall drops in that cycle via bypass).
- Reset (rst low, asynchronous): all registers 0, busy all 0; while low, rd_data = 0 and stall = 0 regardless of inputs; writes and issues ignored. Release is synchronous to the next posedge; first write accepted on the first edge with rst high.

## Structure
- Shared package: NULL_REG default, special indices REG_SP = 8, REG_T = 9, REG_IH = 10, and DATA_W/ADDR_W defaults, used by decode and write-back.
- Sub-module id_scoreboard: busy vector with set/clear/flush logic and stall generation; the top holds storage and the read/bypass muxes.

## Test plan
- Reset: rst low mid-run after writing reg 3 = 16'h1234 -> rd_data all 0, busy 0, stall 0; after release reg 3 reads 0.
- Write/read/bypass: wb_en, wb_addr 2, wb_data 16'hBEEF with rd_addr0 = 2 same cycle -> rd_data0 = 16'hBEEF that cycle and all later cycles.
- NULL register: write 16'hFFFF to index 15 -> read index 15 returns 0, busy[15] never set on iss_load to 15.
- Load-use: issue load to reg 5; next cycle rd_addr1 = 5 -> stall 1; hold 3 cycles; wb_en reg 5 = 16'h0042 -> stall 0 and rd_data1 = 16'h0042 in that cycle; busy[5] 0 next cycle.
- Simultaneous: wb_en reg 4 and iss_load reg 4 same edge -> busy[4] = 1 afterwards; flush with iss_load reg 6 same edge -> busy all 0.
- Special regs: write SP (8) = 16'hBF00, T (9) = 1 via ports 0/1 reads -> correct values, multiple ports reading same index agree.
